tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter_pkg.sv | 22 ++
 rtl/tx_arbiter_rr_select.sv | 30 +++
 rtl/tx_arbiter.sv | 142 ++++++++++++++
 tb/tb_tx_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared tx_protocol-family definitions: header magic, FSM state encodings, frame counter width.
// The CHECKSUM state exists only when TX_CHECKSUM_EN is defined.
package tx_arbiter_pkg;

   localparam logic [7:0] HDR_MAGIC   = 8'hA0;
   localparam int         FRAME_CNT_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HEADER   = 2'd1,
      ST_PAYLOAD  = 2'd2
`ifdef TX_CHECKSUM_EN
      ,ST_CHECKSUM = 2'd3
`endif
   } state_e;

   // Header word carries the owning source index in its low nibble.
   function automatic logic [7:0] header_word(input logic [3:0] id);
      return HDR_MAGIC | {4'h0, id};
   endfunction

endpackage

// File: rtl/tx_arbiter_rr_select.sv
// Round-robin selector: first requester strictly after last_i, ascending with wrap.
// Purely combinational; the caller registers the winner.
module rr_select import tx_arbiter_pkg::*; #(
   parameter int N = 3
) (
   input  logic [N-1:0] req_i,
   input  logic [3:0]   last_i,
   output logic [3:0]   winner_o,
   output logic         any_o
);

   int cand;

   // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
   always_comb begin
      winner_o = '0;
      any_o    = 1'b0;
      cand     = 0;
      for (int i = 1; i <= N; i++) begin
         // last_i < N and i <= N, so a single subtraction performs the wrap
         cand = int'(last_i) + i;
         if (cand >= N) cand = cand - N;
         if (!any_o && req_i[cand]) begin
            any_o    = 1'b1;
            winner_o = 4'(cand);
         end
      end
   end

endmodule

// File: rtl/tx_arbiter.sv
// Frames words from SOURCES requesters onto one FT245-style sink: header, payload, optional checksum.
// Define TX_CHECKSUM_EN to append an XOR checksum word after each frame's payload.
module tx_arbiter import tx_arbiter_pkg::*; #(
   parameter int DATA_WIDTH = 8,
   parameter int SOURCES    = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [SOURCES*DATA_WIDTH-1:0] src_data,
   input  logic [SOURCES-1:0]            src_rdy,
   input  logic [SOURCES-1:0]            src_eof,
   output logic [SOURCES-1:0]            src_ack,
   output logic [DATA_WIDTH-1:0]         tx_data,
   output logic                          tx_rdy,
   input  logic                          tx_ack,
   output logic [3:0]                    grant_id,
   output logic                          busy,
   output logic [FRAME_CNT_W-1:0]        frame_cnt
);

   state_e                   state_q;
   logic [3:0]               grant_q, last_q;
   logic [FRAME_CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [DATA_WIDTH-1:0]    sel_data;
   logic                     sel_rdy, sel_eof;
   logic [SOURCES-1:0]       grant_mask;
   logic [3:0]               rr_winner;
   logic                     rr_any;
   logic                     xfer;
`ifdef TX_CHECKSUM_EN
   logic [7:0]               csum_q, csum_d;
`endif

   rr_select #(.N(SOURCES)) u_rr (
      .req_i    (src_rdy),
      .last_i   (last_q),
      .winner_o (rr_winner),
      .any_o    (rr_any)
   );

   always_comb begin
      sel_data   = '0;
      sel_rdy    = 1'b0;
      sel_eof    = 1'b0;
      grant_mask = '0;
      for (int k = 0; k < SOURCES; k++) begin
         if (grant_q == 4'(k)) begin
            sel_data      = src_data[k*DATA_WIDTH +: DATA_WIDTH];
            sel_rdy       = src_rdy[k];
            sel_eof       = src_eof[k];
            grant_mask[k] = 1'b1;
         end
      end
   end

   // Payload words pass straight through so the granted source sees the sink's ack in the same cycle.
   always_comb begin
      tx_data = '0;
      tx_rdy  = 1'b0;
      src_ack = '0;
      case (state_q)
         ST_HEADER: begin
            tx_rdy  = 1'b1;
            tx_data = DATA_WIDTH'(header_word(grant_q));
         end
         ST_PAYLOAD: begin
            tx_rdy  = sel_rdy;
            tx_data = sel_data;
            src_ack = grant_mask & {SOURCES{tx_ack}};
         end
`ifdef TX_CHECKSUM_EN
         ST_CHECKSUM: begin
            tx_rdy  = 1'b1;
            tx_data = DATA_WIDTH'(csum_q);
         end
`endif
         default: ;
      endcase
   end

   assign xfer        = tx_rdy & tx_ack;
   assign frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
`ifdef TX_CHECKSUM_EN
   assign csum_d      = csum_q ^ sel_data[7:0];
`endif

   assign grant_id  = grant_q;
   assign busy      = (state_q != ST_IDLE);
   assign frame_cnt = frame_cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         last_q      <= 4'(SOURCES-1);
         frame_cnt_q <= '0;
`ifdef TX_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rr_any) begin
                  grant_q <= rr_winner;
                  last_q  <= rr_winner;
                  state_q <= ST_HEADER;
               end
            end
            ST_HEADER: begin
`ifdef TX_CHECKSUM_EN
               csum_q <= '0;
`endif
               if (tx_ack) state_q <= ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
               if (xfer) begin
`ifdef TX_CHECKSUM_EN
                  csum_q <= csum_d;
                  if (sel_eof) state_q <= ST_CHECKSUM;
`else
                  if (sel_eof) begin
                     state_q     <= ST_IDLE;
                     frame_cnt_q <= frame_cnt_d;
                  end
`endif
               end
            end
`ifdef TX_CHECKSUM_EN
            ST_CHECKSUM: begin
               if (tx_ack) begin
                  state_q     <= ST_IDLE;
                  frame_cnt_q <= frame_cnt_d;
               end
            end
`endif
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_arbiter.sv
// Self-checking bench for tx_arbiter: per-source word queues drive the DUT, a scoreboard of expected sink words is checked on each transfer.
// Covers the TX_CHECKSUM_EN build as well when the macro is defined.
module tb_tx_arbiter;

   localparam int DW = 8;
   localparam int NS = 3;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NS*DW-1:0]  src_data = '0;
   logic [NS-1:0]     src_rdy = '0;
   logic [NS-1:0]     src_eof = '0;
   logic [NS-1:0]     src_ack;
   logic [DW-1:0]     tx_data;
   logic              tx_rdy;
   logic              tx_ack = 1'b1;
   logic [3:0]        grant_id;
   logic              busy;
   logic [15:0]       frame_cnt;

   typedef struct packed {
      logic [3:0] stall;
      logic       eof;
      logic [7:0] data;
   } word_t;

   word_t       srcq [NS][$];
   logic [7:0]  sb [$];
   logic [7:0]  exp_csum;
   logic [7:0]  exp_word;
   word_t       head;
   logic [NS-1:0] took;
   logic        tx_ack_en = 1'b1;
   int          vectors = 0;
   int          miscompares = 0;

   always #5 clk = ~clk;

   tx_arbiter #(.DATA_WIDTH(DW), .SOURCES(NS)) dut (
      .clk       (clk),
      .rst       (rst),
      .src_data  (src_data),
      .src_rdy   (src_rdy),
      .src_eof   (src_eof),
      .src_ack   (src_ack),
      .tx_data   (tx_data),
      .tx_rdy    (tx_rdy),
      .tx_ack    (tx_ack),
      .grant_id  (grant_id),
      .busy      (busy),
      .frame_cnt (frame_cnt)
   );

   // One clock: scoreboard check at negedge, then source/sink drive 1 time unit after posedge.
   task automatic tick();
      @(negedge clk);
      if (!rst && tx_rdy && tx_ack) begin
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL tx_word: got %02h, expected no transfer", tx_data);
         end else begin
            exp_word = sb.pop_front();
            if (tx_data !== exp_word) begin
               miscompares++;
               $display("FAIL tx_word: got %02h, expected %02h", tx_data, exp_word);
            end
         end
      end
      took = src_ack & src_rdy;
      @(posedge clk);
      #1;
      for (int k = 0; k < NS; k++) begin
         if (rst) srcq[k].delete();
         else if (took[k] && srcq[k].size() > 0) void'(srcq[k].pop_front());
         if (srcq[k].size() == 0) begin
            src_rdy[k] = 1'b0;
            src_eof[k] = 1'b0;
            src_data[k*DW +: DW] = '0;
         end else begin
            head = srcq[k][0];
            src_eof[k] = head.eof;
            src_data[k*DW +: DW] = head.data;
            if (head.stall != 0) begin
               src_rdy[k] = 1'b0;
               head.stall = head.stall - 4'd1;
               srcq[k][0] = head;
            end else begin
               src_rdy[k] = 1'b1;
            end
         end
      end
      tx_ack = tx_ack_en;
   endtask

   task automatic begin_frame(input int src);
      sb.push_back(8'hA0 | 8'(src));
      exp_csum = 8'h00;
   endtask

   task automatic add_word(input int src, input logic [7:0] d, input logic eof, input int stall);
      word_t w;
      w.data  = d;
      w.eof   = eof;
      w.stall = 4'(stall);
      srcq[src].push_back(w);
      sb.push_back(d);
      exp_csum = exp_csum ^ d;
   endtask

   task automatic end_frame();
`ifdef TX_CHECKSUM_EN
      sb.push_back(exp_csum);
`endif
   endtask

   task automatic wait_busy(input string name);
      int n = 0;
      while (!busy && n < 50) begin
         tick();
         n++;
      end
      vectors++;
      if (!busy) begin
         miscompares++;
         $display("FAIL %s_start: busy stayed 0, expected 1 within 50 cycles", name);
      end
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 300) begin
         tick();
         n++;
      end
      vectors++;
      if (sb.size() != 0 || busy) begin
         miscompares++;
         $display("FAIL %s_done: %0d words outstanding busy=%0b, expected 0 outstanding and idle", name, sb.size(), busy);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      sb.delete();
      for (int k = 0; k < NS; k++) srcq[k].delete();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      vectors++;
      if (busy !== 1'b0 || tx_rdy !== 1'b0 || tx_data !== 8'h00 || src_ack !== 3'b000 ||
          frame_cnt !== 16'h0000 || grant_id !== 4'h0) begin
         miscompares++;
         $display("FAIL reset_state: busy=%0b tx_rdy=%0b tx_data=%02h src_ack=%03b frame_cnt=%04h grant_id=%0h, expected all zero",
                  busy, tx_rdy, tx_data, src_ack, frame_cnt, grant_id);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      begin_frame(1);
      add_word(1, 8'h11, 1'b0, 0);
      add_word(1, 8'h22, 1'b1, 0);
      end_frame();
      wait_done("single");
      vectors++;
      if (frame_cnt !== 16'd1) begin
         miscompares++;
         $display("FAIL single_frame_cnt: got %0d, expected 1", frame_cnt);
      end
      vectors++;
      if (grant_id !== 4'd1) begin
         miscompares++;
         $display("FAIL single_grant: got %0d, expected 1", grant_id);
      end
   endtask

   task automatic test_round_robin();
      int idle = 0;
      int n = 0;
      do_reset();
      begin_frame(0); add_word(0, 8'h50, 1'b1, 0); end_frame();
      begin_frame(1); add_word(1, 8'h60, 1'b1, 0); end_frame();
      begin_frame(2); add_word(2, 8'h70, 1'b1, 0); end_frame();
      begin_frame(0); add_word(0, 8'h51, 1'b1, 0); end_frame();
      wait_busy("rr");
      while (sb.size() != 0 && n < 300) begin
         tick();
         n++;
         if (sb.size() != 0 && !busy) idle++;
      end
      vectors++;
      if (idle !== 3) begin
         miscompares++;
         $display("FAIL back_to_back_idle: got %0d idle cycles over 4 frames, expected 3", idle);
      end
      wait_done("rr");
      vectors++;
      if (frame_cnt !== 16'd4) begin
         miscompares++;
         $display("FAIL rr_frame_cnt: got %0d, expected 4", frame_cnt);
      end
   endtask

   task automatic test_header_hold();
      tx_ack_en = 1'b0;
      begin_frame(0); add_word(0, 8'h5A, 1'b1, 0); end_frame();
      wait_busy("hold");
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (tx_data !== 8'hA0 || tx_rdy !== 1'b1 || src_ack !== 3'b000) begin
            miscompares++;
            $display("FAIL header_hold[%0d]: tx_data=%02h tx_rdy=%0b src_ack=%03b, expected A0 1 000",
                     i, tx_data, tx_rdy, src_ack);
         end
         tick();
      end
      tx_ack_en = 1'b1;
      wait_done("hold");
   endtask

   task automatic test_stall();
      int stall = 0;
      int n = 0;
      begin_frame(1);
      add_word(1, 8'h31, 1'b0, 0);
      add_word(1, 8'h32, 1'b0, 0);
      add_word(1, 8'h33, 1'b1, 3);
      end_frame();
      begin_frame(2); add_word(2, 8'h77, 1'b1, 0); end_frame();
      wait_busy("stall");
      while ((sb.size() != 0 || busy) && n < 300) begin
         if (busy && !tx_rdy) begin
            stall++;
            vectors++;
            if (grant_id !== 4'd1) begin
               miscompares++;
               $display("FAIL stall_grant: got %0d during stall, expected 1", grant_id);
            end
         end
         if (busy && grant_id == 4'd1 && src_ack[2] !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL stall_ack2: src_ack[2]=%0b while source 1 owns output, expected 0", src_ack[2]);
         end
         tick();
         n++;
      end
      vectors++;
      if (stall !== 3) begin
         miscompares++;
         $display("FAIL stall_cycles: got %0d cycles with tx_rdy=0, expected 3", stall);
      end
      wait_done("stall");
      vectors++;
      if (frame_cnt !== 16'd7) begin
         miscompares++;
         $display("FAIL stall_frame_cnt: got %0d, expected 7", frame_cnt);
      end
   endtask

   task automatic test_reset_mid();
      int n = 0;
      begin_frame(0);
      add_word(0, 8'h41, 1'b0, 0);
      add_word(0, 8'h42, 1'b0, 0);
      add_word(0, 8'h43, 1'b1, 0);
      end_frame();
      while (srcq[0].size() > 2 && n < 50) begin
         tick();
         n++;
      end
      rst = 1'b1;
      sb.delete();
      for (int k = 0; k < NS; k++) srcq[k].delete();
      #1;
      vectors++;
      if (busy !== 1'b0 || tx_rdy !== 1'b0 || frame_cnt !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_mid: busy=%0b tx_rdy=%0b frame_cnt=%0d, expected 0 0 0", busy, tx_rdy, frame_cnt);
      end
      tick();
      rst = 1'b0;
      begin_frame(1); add_word(1, 8'h66, 1'b1, 0); end_frame();
      wait_done("after_reset");
      vectors++;
      if (frame_cnt !== 16'd1) begin
         miscompares++;
         $display("FAIL after_reset_frame_cnt: got %0d, expected 1", frame_cnt);
      end
   endtask

   task automatic test_wrap();
      force dut.frame_cnt_q = 16'hFFFF;
      tick();
      vectors++;
      if (frame_cnt !== 16'hFFFF) begin
         miscompares++;
         $display("FAIL wrap_preset: got %04h, expected FFFF", frame_cnt);
      end
      release dut.frame_cnt_q;
      begin_frame(2); add_word(2, 8'h05, 1'b1, 0); end_frame();
      wait_done("wrap");
      vectors++;
      if (frame_cnt !== 16'h0000) begin
         miscompares++;
         $display("FAIL wrap_frame_cnt: got %04h, expected 0000", frame_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_header_hold();
      test_stall();
      test_reset_mid();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
